mux8_rr_arbiter: RTL

Round-robin arbiter and select sequencer for the 8:1 multiplexer (`mux8_1`). Eight requesters, one per data input D0..D7, compete for the shared mux output. The block grants one requester at a time and drives the 3-bit mux select `S` from its `sel` output. It bounds each tenure with a hold limit so no requester starves the others.

---
 rtl/mux8_rr_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for the shared 8:1 mux: grants one requester at a time,
// drives the mux select, and bounds each tenure with an optional hold limit.
module mux8_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] sel,
  output logic [7:0] grant,
  output logic       valid,
  output logic       timeout
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;
  localparam logic [7:0] HOLD_LIM = HOLD_MAX[7:0];

  logic       state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [7:0] grant_q, grant_d;
  logic       valid_q, valid_d;

  logic       hold_hit;
  logic       rel_now;
  logic [2:0] next_ptr;
  logic [2:0] arb_ptr;
  logic [3:0] win;

  // Returns {found, index}; scanning downward lets the nearest-to-pointer hit win.
  function automatic logic [3:0] arbitrate(input logic [7:0] r, input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0;
    for (int k = 7; k >= 0; k--) begin
      idx = p + 3'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    hold_cnt_d = hold_cnt_q;
    grant_d    = grant_q;
    valid_d    = valid_q;

    hold_hit = (HOLD_LIM != 8'd0) && (hold_cnt_q == HOLD_LIM);
    rel_now  = done || !req[sel_q] || hold_hit;
    next_ptr = sel_q + 3'd1;
    // On release the former owner becomes lowest priority in the same-cycle re-arbitration.
    arb_ptr  = (state_q == ST_GRANT) ? next_ptr : ptr_q;
    win      = arbitrate(req, arb_ptr);
    timeout  = (state_q == ST_GRANT) && hold_hit && !done && req[sel_q];

    case (state_q)
      ST_IDLE: begin
        if (win[3]) begin
          state_d    = ST_GRANT;
          sel_d      = win[2:0];
          grant_d    = 8'b1 << win[2:0];
          valid_d    = 1'b1;
          hold_cnt_d = 8'd1;
        end
      end
      default: begin
        if (rel_now) begin
          ptr_d = next_ptr;
          if (win[3]) begin
            state_d    = ST_GRANT;
            sel_d      = win[2:0];
            grant_d    = 8'b1 << win[2:0];
            valid_d    = 1'b1;
            hold_cnt_d = 8'd1;
          end else begin
            state_d = ST_IDLE;
            grant_d = 8'b0;
            valid_d = 1'b0;
          end
        end else if (hold_cnt_q != 8'hFF) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 3'd0;
      sel_q      <= 3'd0;
      hold_cnt_q <= 8'd0;
      grant_q    <= 8'd0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q    <= grant_d;
      valid_q    <= valid_d;
    end
  end

  assign sel   = sel_q;
  assign grant = grant_q;
  assign valid = valid_q;

endmodule
